// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle for counter_seq_ctrl: launch/abort/pause requests and
// latched config in, count/state/busy/done out.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, periodic, limit, prescale,
    input  count, state, busy, done
  );

  modport slave (
    input  start, stop, pause, periodic, limit, prescale,
    output count, state, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Prescaled up-counter sequencer with one-shot/periodic modes, pause and stop.
// Optional macro COUNTER_SEQ_RESTART_EN: start while busy restarts the sequence.
//
// state  | meaning
// IDLE   | counter cleared, waiting for start
// RUN    | prescaler running, counter steps on each tick
// PAUSED | prescaler and counter frozen while pause is high
// DONE   | one-shot finished, count holds limit
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  counter_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_count,    w_count_nxt;
  logic [WIDTH-1:0] r_limit,    w_limit_nxt;
  logic [PRE_W-1:0] r_pre,      w_pre_nxt;
  logic [PRE_W-1:0] r_prescale, w_prescale_nxt;
  logic             r_periodic, w_periodic_nxt;
  logic             r_done,     w_done_nxt;
  logic             w_tick;
  logic             w_restart_ok;
  logic             w_accept_start;

`ifdef COUNTER_SEQ_RESTART_EN
  assign w_restart_ok = 1'b1;
`else
  assign w_restart_ok = 1'b0;
`endif

  assign w_tick         = (r_pre == r_prescale);
  assign w_accept_start = bus.start &&
                          ((r_state == S_IDLE) || (r_state == S_DONE) || w_restart_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_limit    <= '0;
      r_pre      <= '0;
      r_prescale <= '0;
      r_periodic <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_limit    <= w_limit_nxt;
      r_pre      <= w_pre_nxt;
      r_prescale <= w_prescale_nxt;
      r_periodic <= w_periodic_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_limit_nxt    = r_limit;
    w_pre_nxt      = r_pre;
    w_prescale_nxt = r_prescale;
    w_periodic_nxt = r_periodic;
    w_done_nxt     = 1'b0;

    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_pre_nxt   = '0;
    end else if (w_accept_start) begin
      w_state_nxt    = S_RUN;
      w_count_nxt    = '0;
      w_pre_nxt      = '0;
      w_limit_nxt    = bus.limit;
      w_prescale_nxt = bus.prescale;
      w_periodic_nxt = bus.periodic;
    end else begin
      case (r_state)
        S_IDLE: w_count_nxt = '0;
        S_RUN, S_PAUSED: begin
          if (bus.pause) begin
            w_state_nxt = S_PAUSED;
          end else begin
            // The release edge out of PAUSED is itself a running edge.
            w_state_nxt = S_RUN;
            if (w_tick) begin
              w_pre_nxt = '0;
              if (r_count == r_limit) begin
                w_done_nxt = 1'b1;
                if (r_periodic) w_count_nxt = '0;
                else            w_state_nxt = S_DONE;
              end else begin
                w_count_nxt = r_count + 1'b1;
              end
            end else begin
              w_pre_nxt = r_pre + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.count = r_count;
    bus.state = r_state;
    bus.done  = r_done;
    bus.busy  = (r_state == S_RUN) || (r_state == S_PAUSED);
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: an arithmetic reference model predicts
// each edge's outputs into a queue, a negedge monitor pops and compares.
module tb_counter_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

`ifdef COUNTER_SEQ_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int count;
    int state;
    int busy;
    int done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: sequence position expressed as active edges since start.
  int m_state, m_count, m_lim, m_pre, m_e, m_per, m_done;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_count = 0; m_lim = 0; m_pre = 0; m_e = 0; m_per = 0; m_done = 0;
  endfunction

  function automatic void model_edge(int st, int sp, int ps, int per, int lim, int pre);
    int period, ticks;
    m_done = 0;
    if (sp != 0) begin
      m_state = 0;
      m_count = 0;
    end else if (st != 0 && (m_state == 0 || m_state == 3 || RESTART_EN)) begin
      m_lim = lim; m_pre = pre; m_per = per;
      m_e = 0; m_count = 0; m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (ps != 0) begin
        m_state = 2;
      end else begin
        m_state = 1;
        m_e++;
        period = m_pre + 1;
        if (m_e % period == 0) begin
          ticks = m_e / period;
          if (m_per != 0) begin
            m_count = ticks % (m_lim + 1);
            if (m_count == 0) m_done = 1;
          end else if (ticks == m_lim + 1) begin
            m_done  = 1;
            m_state = 3;
            m_count = m_lim;
          end else begin
            m_count = ticks;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("count", int'(bus.count), e.count);
      check("state", int'(bus.state), e.state);
      check("busy",  int'(bus.busy),  e.busy);
      check("done",  int'(bus.done),  e.done);
    end
  end

  task automatic step(int st, int sp, int ps, int per, int lim, int pre);
    exp_t e;
    @(negedge clk);
    #1;
    bus.start    = st[0];
    bus.stop     = sp[0];
    bus.pause    = ps[0];
    bus.periodic = per[0];
    bus.limit    = lim[WIDTH-1:0];
    bus.prescale = pre[PRE_W-1:0];
    model_edge(st, sp, ps, per, lim, pre);
    e.count = m_count;
    e.state = m_state;
    e.busy  = (m_state == 1 || m_state == 2) ? 1 : 0;
    e.done  = m_done;
    sb_q.push_back(e);
  endtask

  task automatic idle_steps(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 15));
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_done",  int'(bus.done),  0);
    model_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.periodic = 1'b0;
    bus.limit = '0; bus.prescale = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_state", int'(bus.state), 0);
    check("init_count", int'(bus.count), 0);
    #1 reset = 1'b0;
    idle_steps(3);

    // one-shot limit=5 prescale=0; config changes while busy must be ignored
    step(1, 0, 0, 0, 5, 0);
    idle_steps(9);

    // periodic limit=3 prescale=1 for three-plus periods
    step(1, 0, 0, 1, 3, 1);
    idle_steps(26);
    step(0, 1, 0, 0, 0, 0);

    // pause for 7 cycles at count=4 of a limit=10 prescale=2 one-shot
    step(1, 0, 0, 0, 10, 2);
    idle_steps(12);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
    idle_steps(24);

    // start+stop in IDLE, then from DONE
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 4, 0);
    idle_steps(2);
    // stop exactly on the terminal tick
    step(1, 0, 0, 0, 2, 0);
    idle_steps(2);
    step(0, 1, 0, 0, 0, 0);
    idle_steps(2);
    // limit=0 prescale=0: done on first RUN edge
    step(1, 0, 0, 0, 0, 0);
    idle_steps(2);

    // start at count=7 of limit=9: restart or ignored depending on build
    step(1, 0, 0, 0, 9, 0);
    idle_steps(7);
    step(1, 0, 0, 0, 9, 0);
    idle_steps(12);
    // start coinciding with pause while busy
    step(1, 0, 0, 1, 6, 1);
    idle_steps(3);
    step(1, 0, 1, 1, 4, 0);
    step(0, 0, 1, 0, 0, 0);
    idle_steps(4);

    // async reset mid-run at count=3
    step(1, 0, 0, 0, 8, 0);
    idle_steps(3);
    async_reset_check();
    idle_steps(2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 79) == 0) ? 1 : 0,
           ($urandom_range(0, 9) == 0) ? 1 : 0,
           $urandom_range(0, 1),
           $urandom_range(0, 11),
           $urandom_range(0, 3));
      if (i % 1000 == 999) async_reset_check();
    end

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
